// File: rtl/simt_scheduler.sv
// SIMT block scheduler: walks one block through FETCH..UPDATE and manages lane divergence.
// Latency: 6 cycles per instruction once the fetch completes, plus any LSU wait; holds in FETCH/WAIT, no other stalls.
// Build option: define SIMT_RECONV_STACK_EN for the reconvergence stack; without it the launch mask runs in lockstep.
module simt_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int STACK_DEPTH       = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
    input  logic [2:0]                             fetcher_state,
    input  logic                                   decoded_ret,
    input  logic                                   decoded_sync,
    input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
    input  logic [PC_BITS*THREADS_PER_BLOCK-1:0]   next_pc,
    output logic [2:0]                             core_state,
    output logic [PC_BITS-1:0]                     current_pc,
    output logic [THREADS_PER_BLOCK-1:0]           active_mask,
    output logic                                   done,
    output logic                                   stack_overflow
);
    localparam int T   = THREADS_PER_BLOCK;
    localparam int TCW = $clog2(T) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [PC_BITS-1:0]   pc_q, pc_d;
    logic [T-1:0]         mask_q, mask_d;
    logic [T-1:0]         launch_mask;
    logic                 lsu_busy;
    logic [PC_BITS-1:0]   tgt;
    logic                 tgt_found;

    // Lane-level decode: launch mask, LSU busy on active lanes, branch target of lowest active lane.
    always_comb begin
        launch_mask = '0;
        lsu_busy    = 1'b0;
        tgt         = '0;
        tgt_found   = 1'b0;
        for (int i = 0; i < T; i++) begin
            launch_mask[i] = (TCW'(i) < thread_count);
            if (mask_q[i] && (lsu_state[2*i +: 2] == 2'd1 || lsu_state[2*i +: 2] == 2'd2))
                lsu_busy = 1'b1;
            if (mask_q[i] && !tgt_found) begin
                tgt       = next_pc[PC_BITS*i +: PC_BITS];
                tgt_found = 1'b1;
            end
        end
    end

`ifdef SIMT_RECONV_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    logic [PC_BITS-1:0] stk_pc_q    [STACK_DEPTH];
    logic [PC_BITS-1:0] stk_pc_d    [STACK_DEPTH];
    logic [T-1:0]       stk_pend_q  [STACK_DEPTH];
    logic [T-1:0]       stk_pend_d  [STACK_DEPTH];
    logic [T-1:0]       stk_merge_q [STACK_DEPTH];
    logic [T-1:0]       stk_merge_d [STACK_DEPTH];
    logic [SPW-1:0]     sp_q, sp_d;
    logic               ovf_q, ovf_d;
    logic [T-1:0]       taken, rest;
    logic [PC_BITS-1:0] rest_pc;
    logic               rest_found;
    logic [PC_BITS-1:0] top_pc;
    logic [T-1:0]       top_pend, top_merge;
    logic               stack_full;

    always_comb begin
        taken      = '0;
        rest_pc    = '0;
        rest_found = 1'b0;
        for (int i = 0; i < T; i++)
            taken[i] = mask_q[i] && (next_pc[PC_BITS*i +: PC_BITS] == tgt);
        rest = mask_q & ~taken;
        for (int i = 0; i < T; i++) begin
            if (rest[i] && !rest_found) begin
                rest_pc    = next_pc[PC_BITS*i +: PC_BITS];
                rest_found = 1'b1;
            end
        end
        top_pc    = '0;
        top_pend  = '0;
        top_merge = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) begin
                top_pc    = stk_pc_q[i];
                top_pend  = stk_pend_q[i];
                top_merge = stk_merge_q[i];
            end
        end
        stack_full = (sp_q == SPW'(STACK_DEPTH));
    end
`else
    logic unused_sync;
    assign unused_sync = decoded_sync & (STACK_DEPTH != 0);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mask_d  = mask_q;
`ifdef SIMT_RECONV_STACK_EN
        sp_d        = sp_q;
        ovf_d       = ovf_q;
        stk_pc_d    = stk_pc_q;
        stk_pend_d  = stk_pend_q;
        stk_merge_d = stk_merge_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = launch_mask;
                    pc_d    = '0;
                    state_d = (thread_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   if (fetcher_state == 3'b010) state_d = S_DECODE;
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: state_d = S_WAIT;
            S_WAIT:    if (!lsu_busy) state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                state_d = S_FETCH;
`ifdef SIMT_RECONV_STACK_EN
                if (decoded_ret && sp_q == '0) begin
                    state_d = S_DONE;
                end else if ((decoded_sync || decoded_ret) && sp_q != '0) begin
                    // First SYNC hands the pending lanes their turn; the second merges them back.
                    if (top_pend != '0) begin
                        mask_d = top_pend;
                        pc_d   = top_pc;
                        for (int i = 0; i < STACK_DEPTH; i++)
                            if (sp_q == SPW'(i + 1)) stk_pend_d[i] = '0;
                    end else begin
                        mask_d = top_merge;
                        pc_d   = tgt;
                        sp_d   = sp_q - SPW'(1);
                    end
                end else if (rest == '0) begin
                    pc_d = tgt;
                end else if (!stack_full) begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (sp_q == SPW'(i)) begin
                            stk_pc_d[i]    = rest_pc;
                            stk_pend_d[i]  = rest;
                            stk_merge_d[i] = mask_q;
                        end
                    end
                    sp_d   = sp_q + SPW'(1);
                    mask_d = taken;
                    pc_d   = tgt;
                end else begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end
`else
                if (decoded_ret) state_d = S_DONE;
                else             pc_d    = tgt;
`endif
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mask_q  <= mask_d;
        end
    end

`ifdef SIMT_RECONV_STACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_pc_q[i]    <= '0;
                stk_pend_q[i]  <= '0;
                stk_merge_q[i] <= '0;
            end
        end else begin
            sp_q        <= sp_d;
            ovf_q       <= ovf_d;
            stk_pc_q    <= stk_pc_d;
            stk_pend_q  <= stk_pend_d;
            stk_merge_q <= stk_merge_d;
        end
    end
    assign stack_overflow = ovf_q;
`else
    assign stack_overflow = 1'b0;
`endif

    assign core_state  = state_q;
    assign current_pc  = pc_q;
    assign active_mask = mask_q;
    assign done        = (state_q == S_DONE);
endmodule

// File: tb/tb_simt_scheduler.sv
// Bench for simt_scheduler: instruction vector tables plus hand sequences for reset, LSU wait and overflow.
module tb_simt_scheduler;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  thread_count, fetcher_state;
    logic        decoded_ret, decoded_sync;
    logic [7:0]  lsu_state;
    logic [31:0] next_pc;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic [3:0]  active_mask;
    logic        done, stack_overflow;

    always #5 clk = ~clk;

    simt_scheduler #(.THREADS_PER_BLOCK(4), .PC_BITS(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .fetcher_state(fetcher_state), .decoded_ret(decoded_ret), .decoded_sync(decoded_sync),
        .lsu_state(lsu_state), .next_pc(next_pc), .core_state(core_state),
        .current_pc(current_pc), .active_mask(active_mask), .done(done),
        .stack_overflow(stack_overflow)
    );

`ifdef SIMT_RECONV_STACK_EN
    logic [2:0] s_state;
    logic [7:0] s_pc;
    logic [3:0] s_mask;
    logic       s_done, s_ovf;

    simt_scheduler #(.THREADS_PER_BLOCK(4), .PC_BITS(8), .STACK_DEPTH(1)) dut_d1 (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .fetcher_state(fetcher_state), .decoded_ret(decoded_ret), .decoded_sync(decoded_sync),
        .lsu_state(lsu_state), .next_pc(next_pc), .core_state(s_state),
        .current_pc(s_pc), .active_mask(s_mask), .done(s_done),
        .stack_overflow(s_ovf)
    );
`endif

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] npc;
        logic        ret;
        logic        sync;
        logic [7:0]  epc;
        logic [3:0]  emask;
        logic        edone;
    } vec_t;

    typedef struct {
        logic [7:0] pc;
        logic [3:0] mask;
        logic       done;
        int         cycles;
    } exp_t;

    vec_t va[$];
    vec_t vb[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wait_pc;

    function automatic logic [31:0] np(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic vec_t mk(input int pc, input logic [31:0] npc, input logic ret,
                                input logic sync, input int epc, input logic [3:0] em,
                                input logic ed);
        vec_t v;
        v.pc = pc[7:0]; v.npc = npc; v.ret = ret; v.sync = sync;
        v.epc = epc[7:0]; v.emask = em; v.edone = ed;
        return v;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [2:0] tc);
        decoded_ret  = 1'b0;
        decoded_sync = 1'b0;
        thread_count = tc;
        start        = 1'b1;
        tick;
        start        = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
    endtask

    // Issue one instruction from FETCH and score the state it lands in.
    task automatic run_row(input vec_t v);
        exp_t e;
        int   cyc;
        chk("pc_before", current_pc, v.pc);
        next_pc       = v.npc;
        decoded_ret   = v.ret;
        decoded_sync  = v.sync;
        fetcher_state = 3'b010;
        e.pc = v.epc; e.mask = v.emask; e.done = v.edone; e.cycles = 6;
        sb.push_back(e);
        cyc = 0;
        do begin
            tick;
            cyc++;
            fetcher_state = 3'b000;
        end while (core_state != 3'd1 && core_state != 3'd7 && cyc < 40);
        e = sb.pop_front();
        chk("cycles", cyc, e.cycles);
        chk("done", done, e.done);
        if (!e.done) begin
            chk("pc", current_pc, e.pc);
            chk("mask", active_mask, e.mask);
        end
    endtask

    initial begin
        for (int k = 0; k < 5; k++)
            va.push_back(mk(k, np(k+1, k+1, k+1, k+1), 1'b0, 1'b0, k+1, 4'hF, 1'b0));
        va.push_back(mk(5, np(6, 6, 6, 6), 1'b1, 1'b0, 5, 4'hF, 1'b1));
`ifdef SIMT_RECONV_STACK_EN
        vb.push_back(mk(0,  np(3, 3, 3, 3),           1'b0, 1'b0, 3,  4'hF, 1'b0));
        vb.push_back(mk(3,  np(9, 9, 4, 4),           1'b0, 1'b0, 9,  4'h3, 1'b0));
        vb.push_back(mk(9,  np(10, 10, 'h55, 'h66),   1'b0, 1'b0, 10, 4'h3, 1'b0));
        vb.push_back(mk(10, np(12, 12, 1, 1),         1'b0, 1'b0, 12, 4'h3, 1'b0));
        vb.push_back(mk(12, np(13, 13, 2, 2),         1'b0, 1'b1, 4,  4'hC, 1'b0));
        vb.push_back(mk(4,  np('h77, 'h77, 12, 12),   1'b0, 1'b0, 12, 4'hC, 1'b0));
        vb.push_back(mk(12, np('h70, 'h70, 13, 13),   1'b0, 1'b1, 13, 4'hF, 1'b0));
        vb.push_back(mk(13, np(20, 20, 30, 30),       1'b0, 1'b0, 20, 4'h3, 1'b0));
        vb.push_back(mk(20, np(21, 22, 0, 0),         1'b0, 1'b0, 21, 4'h1, 1'b0));
        vb.push_back(mk(21, np(5, 5, 5, 5),           1'b1, 1'b0, 22, 4'h2, 1'b0));
        wait_pc = 22;
`else
        vb.push_back(mk(0,  np(3, 3, 3, 3),           1'b0, 1'b0, 3,  4'hF, 1'b0));
        vb.push_back(mk(3,  np(9, 9, 4, 4),           1'b0, 1'b0, 9,  4'hF, 1'b0));
        vb.push_back(mk(9,  np(10, 11, 12, 13),       1'b0, 1'b0, 10, 4'hF, 1'b0));
        vb.push_back(mk(10, np(21, 5, 5, 5),          1'b0, 1'b1, 21, 4'hF, 1'b0));
        wait_pc = 21;
`endif

        reset = 1'b0; start = 1'b0; thread_count = 3'd0; fetcher_state = 3'd0;
        decoded_ret = 1'b0; decoded_sync = 1'b0; lsu_state = 8'h00; next_pc = 32'h0;
        tick;
        start = 1'b1; thread_count = 3'd4;
        tick;
        chk("rst_state", core_state, 3'd0);
        chk("rst_pc", current_pc, 8'd0);
        chk("rst_mask", active_mask, 4'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", stack_overflow, 1'b0);
        start = 1'b0;
        reset = 1'b1;
        tick;

        launch(3'd0);
        chk("tc0_state", core_state, 3'd7);
        chk("tc0_done", done, 1'b1);
        do_reset;

        // Straight-line kernel, RET at pc 5.
        launch(3'd4);
        chk("launch_state", core_state, 3'd1);
        chk("launch_mask", active_mask, 4'hF);
        fetcher_state = 3'b001;
        tick; tick; tick;
        chk("fetch_hold", core_state, 3'd1);
        foreach (va[k]) run_row(va[k]);
        launch(3'd4);
        chk("start_in_done", core_state, 3'd7);

        // Divergence / reconvergence kernel.
        do_reset;
        launch(3'd4);
        foreach (vb[k]) begin
            run_row(vb[k]);
`ifdef SIMT_RECONV_STACK_EN
            if (vb[k].pc == 8'd13) chk("d1_ovf_clear", s_ovf, 1'b0);
            if (vb[k].pc == 8'd20) begin
                chk("d1_ovf", s_ovf, 1'b1);
                chk("d1_state", s_state, 3'd7);
                chk("d1_done", s_done, 1'b1);
            end
`endif
        end
        chk("main_ovf", stack_overflow, 1'b0);

        // Reset in WAIT with lanes 0 and 1 blocked on the LSU.
        begin
            int cyc;
            chk("pc_pre_wait", current_pc, wait_pc);
            lsu_state = 8'h0A; fetcher_state = 3'b010;
            decoded_ret = 1'b0; decoded_sync = 1'b0;
            cyc = 0;
            do begin
                tick;
                cyc++;
                fetcher_state = 3'b000;
            end while (core_state != 3'd4 && cyc < 20);
            chk("enter_wait", core_state, 3'd4);
            tick; tick;
            chk("hold_wait", core_state, 3'd4);
            #2 reset = 1'b0;
            #1;
            chk("arst_state", core_state, 3'd0);
            chk("arst_pc", current_pc, 8'd0);
            chk("arst_mask", active_mask, 4'h0);
            chk("arst_done", done, 1'b0);
            chk("arst_ovf", stack_overflow, 1'b0);
`ifdef SIMT_RECONV_STACK_EN
            chk("arst_d1_done", s_done, 1'b0);
            chk("arst_d1_ovf", s_ovf, 1'b0);
`endif
            tick;
            lsu_state = 8'h00;
            reset = 1'b1;
            launch(3'd4);
            chk("relaunch_state", core_state, 3'd1);
            chk("relaunch_pc", current_pc, 8'd0);
            chk("relaunch_mask", active_mask, 4'hF);
            run_row(mk(0, np(1, 1, 1, 1), 1'b0, 1'b1, 1, 4'hF, 1'b0));
            run_row(mk(1, np(2, 2, 2, 2), 1'b1, 1'b0, 1, 4'hF, 1'b1));
        end

        // Two live lanes: lane 1 stalls five cycles, inactive lane 3 waits forever.
        begin
            int cyc;
            do_reset;
            launch(3'd2);
            chk("tc2_mask", active_mask, 4'h3);
            lsu_state = 8'h8B; fetcher_state = 3'b010;
            next_pc = np(1, 1, 1, 1); decoded_ret = 1'b1;
            cyc = 0;
            do begin
                tick;
                cyc++;
                fetcher_state = 3'b000;
            end while (core_state != 3'd4 && cyc < 20);
            chk("tc2_enter_wait", core_state, 3'd4);
            for (int i = 0; i < 5; i++) tick;
            chk("tc2_wait_lane1", core_state, 3'd4);
            lsu_state = 8'h83;
            tick;
            chk("tc2_exec", core_state, 3'd5);
            tick;
            chk("tc2_update", core_state, 3'd6);
            tick;
            chk("tc2_done", done, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/simt_scheduler.md
SIMT_SCHEDULER -- requirements
Module: simt_scheduler

Interface
REQ-001 SHALL have parameter THREADS_PER_BLOCK, default 4, number of thread lanes (T).
REQ-002 SHALL have parameter PC_BITS, default 8, program counter width.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, reconvergence stack entries (D ≥ 1).
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port: start  input  1  launch kernel on block.
REQ-007 SHALL have port: thread_count  input  $clog2(T)+1  live threads in block.
REQ-008 SHALL have port: fetcher_state  input  3  fetcher state (3'b010 = FETCHED).
REQ-009 SHALL have port: decoded_ret  input  1  current instruction is RET.
REQ-010 SHALL have port: decoded_sync  input  1  current instruction is SYNC (reconvergence point).
REQ-011 SHALL have port: lsu_state  input  2*T  per-lane LSU state, lane i at [2i+1:2i] (0 IDLE, 1 REQUESTING, 2 WAITING, 3 DONE).
REQ-012 SHALL have port: next_pc  input  PC_BITS*T  per-lane next PC, lane i at [PC_BITS*i +: PC_BITS].
REQ-013 SHALL have port: core_state  output  3  pipeline state.
REQ-014 SHALL have port: current_pc  output  PC_BITS  PC being fetched and executed.
REQ-015 SHALL have port: active_mask  output  T  lanes executing current instruction.
REQ-016 SHALL have port: done  output  1  block finished.
REQ-017 SHALL have port: stack_overflow  output  1  sticky, divergence with full stack.

Function
REQ-018 SHALL encode core_state as IDLE 0, FETCH 1, DECODE 2, REQUEST 3, WAIT 4, EXECUTE 5, UPDATE 6, DONE 7.
REQ-019 IDLE SHALL, on start=1, load active_mask with the low thread_count bits set, load current_pc 0, and go to FETCH; thread_count=0 SHALL go directly to DONE.
REQ-020 FETCH SHALL hold until fetcher_state==3'b010, then go to DECODE.
REQ-021 DECODE and REQUEST SHALL each last exactly one cycle, then advance to REQUEST and WAIT respectively.
REQ-022 WAIT SHALL hold while any active lane's lsu_state is REQUESTING or WAITING; inactive lanes SHALL be ignored. It SHALL advance to EXECUTE in the first cycle with no such lane.
REQ-023 EXECUTE SHALL last one cycle, then go to UPDATE.
REQ-024 UPDATE SHALL go to DONE on decoded_ret=1 with the stack empty, regardless of other inputs; otherwise it SHALL go to FETCH.
REQ-025 UPDATE divergence rule: tgt = next_pc of lowest active lane; taken = active lanes with next_pc==tgt; rest = active & ~taken.
REQ-026 If rest==0, UPDATE SHALL set current_pc=tgt and leave the mask unchanged.
REQ-027 If rest!=0 and the stack is not full, UPDATE SHALL push {resume_pc = next_pc of lowest rest lane, pending = rest, merge = active_mask}, then set active_mask=taken and current_pc=tgt.
REQ-028 If rest!=0 and the stack is full, UPDATE SHALL set stack_overflow=1, push nothing, and go to DONE.
REQ-029 On decoded_sync with the stack empty, UPDATE SHALL treat the instruction as a normal instruction under REQ-025/026.
REQ-030 On decoded_sync with top.pending!=0, UPDATE SHALL set active_mask=top.pending, current_pc=top.resume_pc, and top.pending=0.
REQ-031 On decoded_sync with top.pending==0, UPDATE SHALL pop the stack and set active_mask=top.merge, current_pc=tgt.
REQ-032 decoded_ret with the stack non-empty SHALL be handled as decoded_sync; the block SHALL retire only at stack-empty RET.
REQ-033 DONE SHALL drive done=1 and hold until reset; start SHALL be ignored in DONE and in every non-IDLE state.
REQ-034 PC arithmetic SHALL be modulo 2^PC_BITS; next_pc values SHALL be used unmodified.

Reset
REQ-035 While reset=0, outputs SHALL be: core_state IDLE, current_pc 0, active_mask 0, done 0, stack_overflow 0, and the stack SHALL be empty.
REQ-036 Reset asserted mid-kernel SHALL abort immediately and asynchronously; the block SHALL accept start in the first edge after release.

Configuration
REQ-037 Macro SIMT_RECONV_STACK_EN defined: REQ-025..032 SHALL apply with a D-entry stack.
REQ-038 Macro SIMT_RECONV_STACK_EN undefined: no stack SHALL be built; UPDATE SHALL set current_pc = next_pc of the lowest active lane; decoded_sync SHALL be ignored; active_mask SHALL stay at its launch value; stack_overflow SHALL be tied 0.

Verification
REQ-039 Bench: thread_count=4, all lanes next_pc=current_pc+1, LSUs IDLE -> each instruction takes 6 cycles after FETCHED, mask 4'b1111, RET at pc 5 -> done=1.
REQ-040 Bench: at pc 3, lanes 0,1 next_pc=9 and lanes 2,3 next_pc=4 -> mask 4'b0011, pc 9, one stack entry {4, 4'b1100, 4'b1111}.
REQ-041 Bench: continue REQ-040, SYNC at pc 12 -> mask 4'b1100, pc 4; second SYNC at 12 with next_pc 13 -> mask 4'b1111, pc 13, stack empty.
REQ-042 Bench: D=1, nested divergence while one entry is held -> stack_overflow=1, core_state DONE, done=1.
REQ-043 Bench: thread_count=2, lane 1 lsu_state WAITING for 5 cycles, lane 3 WAITING forever -> WAIT exits after lane 1 clears.
REQ-044 Bench: reset pulsed low in WAIT with 2 stack entries -> all outputs at reset values; new start relaunches from pc 0 with a full mask.
